// File: rtl/kernel_pack_if.sv
// -----------------------------------------------------------------------------
// kernel_pack_if
//
// Bundles the kernel/bias stream coming from the host DMA and the packed
// kernel-memory write side of kernel_pack into one interface.
//
// Signals:
//   str_data    [STR_WIDTH]   stream beat
//   str_last                  final beat of a packet
//   str_val                   beat valid
//   str_rdy                   beat accepted when str_val & str_rdy
//   wr_data     [WIDE]        packed kernel word
//   wr_data_val               word valid
//   wr_data_rdy               downstream ready
//   wr_last                   word closes a packet
//   wr_addr     [MEM_AWIDTH]  memory address of the current wr_data word
//   pkt_start   [MEM_AWIDTH]  address of first (bias) word of last packet
//   pkt_end     [MEM_AWIDTH]  address of last word of last packet
//   pkt_done                  one-cycle pulse, packet fully handed off
//
// Modports:
//   master : the packer (kernel_pack)
//   slave  : the environment (DMA source + kernel memory / layer controller)
// -----------------------------------------------------------------------------
interface kernel_pack_if #(
    parameter int STR_WIDTH  = 64,
    parameter int WIDE       = 1024,
    parameter int MEM_AWIDTH = 16
);
    logic [STR_WIDTH-1:0]  str_data;
    logic                  str_last;
    logic                  str_val;
    logic                  str_rdy;
    logic [WIDE-1:0]       wr_data;
    logic                  wr_data_val;
    logic                  wr_data_rdy;
    logic                  wr_last;
    logic [MEM_AWIDTH-1:0] wr_addr;
    logic [MEM_AWIDTH-1:0] pkt_start;
    logic [MEM_AWIDTH-1:0] pkt_end;
    logic                  pkt_done;

    modport master (
        input  str_data, str_last, str_val, wr_data_rdy,
        output str_rdy, wr_data, wr_data_val, wr_last, wr_addr,
               pkt_start, pkt_end, pkt_done
    );

    modport slave (
        output str_data, str_last, str_val, wr_data_rdy,
        input  str_rdy, wr_data, wr_data_val, wr_last, wr_addr,
               pkt_start, pkt_end, pkt_done
    );
endinterface

// File: rtl/kernel_pack.sv
// -----------------------------------------------------------------------------
// kernel_pack
//
// Upstream feeder for the kernel memory. Packs consecutive narrow stream beats
// into one full-width kernel word (GROUP_NB*KER_WIDTH*DEPTH_NB bits) per
// memory location, and tracks the memory address each word lands at so the
// layer controller can form read-region start/end values. The first word of
// each packet is the bias word; a packet ends with str_last.
//
// Parameters:
//   GROUP_NB    convolution groups
//   KER_WIDTH   bits per kernel value
//   DEPTH_NB    kernel values per group
//   STR_WIDTH   stream width; must divide WIDE with at least two beats/word
//   MEM_AWIDTH  kernel memory address width
//
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   kernel_pack_if.master: stream in, packed word out, packet tracking
// -----------------------------------------------------------------------------
module kernel_pack #(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int DEPTH_NB   = 16,
    parameter int STR_WIDTH  = 64,
    parameter int MEM_AWIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    kernel_pack_if.master bus
);
    localparam int WIDE  = GROUP_NB * KER_WIDTH * DEPTH_NB;
    localparam int BEATS = WIDE / STR_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [WIDE-1:0]       buf_q,       buf_d;
    logic [WIDE-1:0]       wr_data_q,   wr_data_d;
    logic                  wr_val_q,    wr_val_d;
    logic                  wr_last_q,   wr_last_d;
    logic [MEM_AWIDTH-1:0] wr_addr_q,   wr_addr_d;
    logic                  pkt_first_q, pkt_first_d;
    logic [MEM_AWIDTH-1:0] start_q,     start_d;
    logic [MEM_AWIDTH-1:0] pkt_start_q, pkt_start_d;
    logic [MEM_AWIDTH-1:0] pkt_end_q,   pkt_end_d;
    logic                  pkt_done_q,  pkt_done_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic            str_rdy;
    logic            beat_acc;
    logic            word_cmp;
    logic            out_hs;
    logic [WIDE-1:0] merged;

    // Ready depends only on the output register and downstream ready, so
    // there is no combinational path from str_val/str_last to str_rdy.
    assign str_rdy  = ~wr_val_q | bus.wr_data_rdy;
    assign beat_acc = bus.str_val & str_rdy;
    assign word_cmp = beat_acc & ((cnt_q == CNT_LAST) | bus.str_last);
    assign out_hs   = wr_val_q & bus.wr_data_rdy;

    // Buffer with the current beat dropped into lane cnt_q. Lanes above
    // cnt_q are still zero, which is what zero-fills a short final word.
    always_comb begin
        merged = buf_q;
        for (int l = 0; l < BEATS; l++) begin
            if (cnt_q == CNT_W'(l)) begin
                merged[l*STR_WIDTH +: STR_WIDTH] = bus.str_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    // NOTE: every _d is given its hold value first, so no path through this
    // block leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        wr_data_d   = wr_data_q;
        wr_val_d    = wr_val_q;
        wr_last_d   = wr_last_q;
        wr_addr_d   = wr_addr_q;
        pkt_first_d = pkt_first_q;
        start_d     = start_q;
        pkt_start_d = pkt_start_q;
        pkt_end_d   = pkt_end_q;
        pkt_done_d  = 1'b0;

        // Beat collection
        if (beat_acc) begin
            if (word_cmp) begin
                cnt_d = '0;
                buf_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                buf_d = merged;
            end
        end

        // Output register. A handshake drains the word; a completion in the
        // same cycle reloads it immediately so back-to-back words have no
        // bubble. Without a handshake wr_val_q stays set (str_rdy is low
        // then, so no completion can overwrite a stalled word).
        if (out_hs) begin
            wr_val_d  = 1'b0;
            wr_addr_d = wr_addr_q + 1'b1;   // wraps with the memory pointer
        end
        if (word_cmp) begin
            wr_data_d = merged;
            wr_last_d = bus.str_last;
            wr_val_d  = 1'b1;
        end

        // Packet tracking. The first word handed off after a packet boundary
        // is the bias word; its address opens the region. For a single-word
        // packet the latch is not yet visible, so the live address is used.
        if (out_hs) begin
            if (pkt_first_q) begin
                start_d     = wr_addr_q;
                pkt_first_d = 1'b0;
            end
            if (wr_last_q) begin
                pkt_start_d = pkt_first_q ? wr_addr_q : start_q;
                pkt_end_d   = wr_addr_q;
                pkt_done_d  = 1'b1;
                pkt_first_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            // NOTE: the accumulation buffer is plain flops, not a RAM, and
            // must be reset: a word cut short by reset must not leak stale
            // lanes into the first word after release.
            buf_q       <= '0;
            wr_data_q   <= '0;
            wr_val_q    <= 1'b0;
            wr_last_q   <= 1'b0;
            wr_addr_q   <= '0;
            pkt_first_q <= 1'b1;
            start_q     <= '0;
            pkt_start_q <= '0;
            pkt_end_q   <= '0;
            pkt_done_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            wr_data_q   <= wr_data_d;
            wr_val_q    <= wr_val_d;
            wr_last_q   <= wr_last_d;
            wr_addr_q   <= wr_addr_d;
            pkt_first_q <= pkt_first_d;
            start_q     <= start_d;
            pkt_start_q <= pkt_start_d;
            pkt_end_q   <= pkt_end_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.str_rdy     = str_rdy;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_data_val = wr_val_q;
    assign bus.wr_last     = wr_last_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.pkt_start   = pkt_start_q;
    assign bus.pkt_end     = pkt_end_q;
    assign bus.pkt_done    = pkt_done_q;

endmodule

// File: doc/kernel_pack.md
# kernel_pack

Upstream feeder for the kernel memory: accepts a narrow kernel/bias stream from the host DMA and packs consecutive beats into one full-width kernel word (GROUP_NB*KER_WIDTH*DEPTH_NB bits) per memory location. It also tracks the memory address each word lands at, so the layer controller can form read-region start/end values. The first word of each packet is the bias word; packets end with str_last.

## Interface

- GROUP_NB, 4, convolution groups
- KER_WIDTH, 16, bits per kernel value
- DEPTH_NB, 16, kernel values per group
- STR_WIDTH, 64, input stream width; must divide WIDE = GROUP_NB*KER_WIDTH*DEPTH_NB; BEATS = WIDE/STR_WIDTH ≥ 2
- MEM_AWIDTH, 16, kernel memory address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- str_data  in  STR_WIDTH  stream beat
- str_last  in  1  final beat of packet
- str_val  in  1  beat valid
- str_rdy  out  1  beat accepted when str_val & str_rdy
- wr_data  out  WIDE  packed word
- wr_data_val  out  1  word valid
- wr_data_rdy  in  1  downstream ready
- wr_last  out  1  word closes a packet
- wr_addr  out  MEM_AWIDTH  memory address of current wr_data word
- pkt_start  out  MEM_AWIDTH  address of first (bias) word of last completed packet
- pkt_end  out  MEM_AWIDTH  address of last word of last completed packet
- pkt_done  out  1  one-cycle pulse, packet fully handed off

## Operation

- Internal: accumulation buffer (WIDE), beat counter cnt (0..BEATS-1), output register (wr_data, wr_last, wr_data_val), address counter, pkt_first flag, start latch.
- str_rdy = ~wr_data_val | wr_data_rdy (combinational from output state and wr_data_rdy only; never from str_val/str_last).
- Beat accept: str_data written to lane cnt (bits [cnt*STR_WIDTH +: STR_WIDTH]); lane 0 = LSBs, first beat.
- Completion: accepted beat with cnt == BEATS-1 or str_last. Output register loads buffer merged with current beat; wr_data_val <= 1; wr_last <= str_last; cnt <= 0; buffer cleared to zero.
- Partial word (str_last before BEATS beats): unfilled lanes are zero.
- Non-completing beat: cnt <= cnt+1, output untouched.
- Output handshake (wr_data_val & wr_data_rdy): wr_addr <= wr_addr+1, modulo 2^MEM_AWIDTH. wr_data_val <= 0 unless a completion occurs the same cycle, in which case the new word loads with no bubble.
- Packet tracking on output handshake:
  - pkt_first set (reset value 1): latch start = wr_addr, clear pkt_first.
  - Word has wr_last: pkt_start <= (pkt_first ? wr_addr : start); pkt_end <= wr_addr; pkt_done pulses next cycle; pkt_first <= 1.
  - A single-word packet gives pkt_start == pkt_end.
- Reset (asynchronous, any time including mid-word): all state cleared; wr_data 0, wr_data_val 0, wr_last 0, wr_addr 0, pkt_start 0, pkt_end 0, pkt_done 0, cnt 0, buffer 0, pkt_first 1; str_rdy 1 after release. Partial beats are discarded.

## Timing

- Latency: completing beat accepted at cycle N → wr_data_val high at N+1.
- Throughput: one beat per cycle while wr_data_rdy is high; one word per BEATS cycles (fewer for partial words).
- Stall: while wr_data_val & ~wr_data_rdy, str_rdy = 0; wr_data, wr_last and wr_addr are held stable. wr_data_val never falls without a handshake.
- pkt_done, pkt_start and pkt_end update one cycle after the handshake of the wr_last word; pkt_start and pkt_end hold until the next packet completes.
- Address wrap: 2^MEM_AWIDTH-1 → 0, matching the kernel memory write pointer. Packet values are raw addresses, so pkt_end < pkt_start is legal.

## Test plan

- Default params, wr_data_rdy=1, 16 beats with value i on beat i, str_last on beat 15 → wr_data_val at cycle after beat 15, lane i == i, wr_last=1, wr_addr=0; pkt_done next cycle with pkt_start=0, pkt_end=0.
- 3 beats 0xA, 0xB, 0xC, last on third → lanes 0..2 = A, B, C; lanes 3..15 = 0; cnt restarts so the next 16-beat word is clean.
- Hold wr_data_rdy=0 when the 2nd word completes → str_rdy=0 and wr_data stable for 5 cycles; release → no beat lost or duplicated, and the following word arrives with no bubble.
- 80-beat packet (5 words), then 32-beat packet → pkt_start/pkt_end = 0/4, then 5/6; pkt_done pulses exactly twice.
- MEM_AWIDTH=4: 14 single-word packets, then a 4-word packet → wr_addr sequence 14, 15, 0, 1; pkt_start=14, pkt_end=1.
- Assert rst asynchronously after 7 beats of a word → all outputs zero immediately without a clock edge; after release, a fresh 16-beat word emits exactly those beats at wr_addr=0.
